// File: rtl/klt_pkg.sv
// Shared types and packet constants for the KLT point telemetry UART.
// The wire frame holds 7 bytes of 10 bits each (start, 8 data LSB first, stop); bit 0 goes out first.
package klt_pkg;

  localparam logic [7:0] KLT_SYNC_BYTE  = 8'hA5;
  localparam int         KLT_PKT_BYTES  = 7;
  localparam int         KLT_X_W        = 12;
  localparam int         KLT_Y_W        = 11;
  localparam int         KLT_FRAME_BITS = KLT_PKT_BYTES * 10;

  typedef struct packed {
    logic [7:0]         frame;
    logic [KLT_X_W-1:0] x;
    logic [KLT_Y_W-1:0] y;
  } klt_sample_t;

  function automatic logic [KLT_FRAME_BITS-1:0] klt_build_frame(input klt_sample_t s);
    logic [7:0]                b [KLT_PKT_BYTES];
    logic [KLT_FRAME_BITS-1:0] f;
    b[0] = KLT_SYNC_BYTE;
    b[1] = s.frame;
    b[2] = {4'b0, s.x[11:8]};
    b[3] = s.x[7:0];
    b[4] = {5'b0, s.y[10:8]};
    b[5] = s.y[7:0];
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    f = '0;
    for (int i = 0; i < KLT_PKT_BYTES; i++) begin
      f[i*10 +: 10] = {1'b1, b[i], 1'b0};
    end
    return f;
  endfunction

endpackage

// File: rtl/klt_sample_fifo.sv
// First-word-fall-through sample FIFO; dout is valid whenever empty is low.
// A push while full is accepted only when a pop happens in the same cycle.
module klt_sample_fifo
  import klt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  klt_sample_t din,
  output klt_sample_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  klt_sample_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, wr_ptr equals rd_ptr; dout is read before this write lands.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/klt_point_uart.sv
// Captures the tracked point on each vsync rise, queues it and streams a 7-byte 8N1 packet.
// Capture to first start bit takes 3 cycles when idle; a capture into a full FIFO is dropped and counted.
module klt_point_uart
  import klt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 644,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               rx_pclk,
  input  logic               rst,
  input  logic               rx_vsync,
  input  logic               enable_tracking,
  input  logic [KLT_X_W-1:0] point_x0,
  input  logic [KLT_Y_W-1:0] point_y0,
  output logic               uart_tx,
  output logic               busy,
  output logic [7:0]         dropped_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam int NBITS = KLT_FRAME_BITS;

  logic                 vsync_q, vsync_d, capture;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]           dropped_q, dropped_d;
  state_t               state_q;
  logic [NBITS-1:0]     shreg_q, load_frame;
  logic [BW-1:0]        baud_q;
  logic [6:0]           bit_q;
  logic                 tx_q, busy_q;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  klt_sample_t          fifo_din, fifo_dout;

  always_comb begin
    vsync_d        = rx_vsync;
    capture        = rx_vsync & ~vsync_q;
    frame_cnt_d    = frame_cnt_q + 8'(capture);
    fifo_push      = capture & enable_tracking;
    fifo_pop       = (state_q == ST_LOAD);
    fifo_din.frame = frame_cnt_q;
    fifo_din.x     = point_x0;
    fifo_din.y     = point_y0;
    load_frame     = klt_build_frame(fifo_dout);
    dropped_d      = dropped_q;
    if (fifo_push && fifo_full && !fifo_pop && dropped_q != 8'hFF) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  // vsync_q follows the input during reset, so a level already high at release is not an edge.
  always_ff @(posedge rx_pclk) begin
    vsync_q <= vsync_d;
    if (rst) begin
      frame_cnt_q <= '0;
      dropped_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      dropped_q   <= dropped_d;
    end
  end

  klt_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (rx_pclk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= ~fifo_empty | (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg_q <= load_frame;
          tx_q    <= load_frame[0];
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (baud_q == BW'(CLKS_PER_BIT - 1)) begin
            baud_q  <= '0;
            shreg_q <= {1'b1, shreg_q[NBITS-1:1]};
            bit_q   <= bit_q + 7'd1;
            if (bit_q == 7'(NBITS - 1)) begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx       = tx_q;
  assign busy          = busy_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_klt_point_uart.sv
// Randomised bench for klt_point_uart: a cycle-level capture/FIFO model predicts the byte stream,
// which is compared with an independent 8N1 decode of the logged uart_tx line.
module tb_klt_point_uart;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int PKT_CYC = 70 * CPB;

  logic        rx_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_vsync = 1'b0;
  logic        enable_tracking = 1'b0;
  logic [11:0] point_x0 = '0;
  logic [10:0] point_y0 = '0;
  logic        uart_tx, busy;
  logic [7:0]  dropped_count;

  klt_point_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .rx_pclk         (rx_pclk),
    .rst             (rst),
    .rx_vsync        (rx_vsync),
    .enable_tracking (enable_tracking),
    .point_x0        (point_x0),
    .point_y0        (point_y0),
    .uart_tx         (uart_tx),
    .busy            (busy),
    .dropped_count   (dropped_count)
  );

  always #5 rx_pclk = ~rx_pclk;

  int cyc = 0;
  always @(posedge rx_pclk) cyc <= cyc + 1;

  logic tx_log[$];
  int   log_base = 0;
  always @(negedge rx_pclk) tx_log.push_back(uart_tx);

  int         n_checks = 0, n_errors = 0;
  logic [7:0] m_frame, m_dropped;
  int         m_loads[$];
  int         m_last_load;
  logic [7:0] exp_bytes[$];
  logic       vs_prev = 1'b0;
  logic [7:0] dec_bytes[$];
  int         dec_first, dec_err;

  logic [7:0] t1_exp[7] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h00, 8'h45, 8'h67};
  logic [7:0] t2_exp[7] = '{8'hA5, 8'h02, 8'h07, 8'hFF, 8'h03, 8'hFF, 8'h06};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_frame     = 8'd0;
    m_dropped   = 8'd0;
    m_last_load = -100000;
    m_loads.delete();
    exp_bytes.delete();
    tx_log.delete();
    log_base = cyc;
  endtask

  // Entry occupancy at cycle c: accepted earlier and not yet loaded before c.
  task automatic model_capture(input int c);
    int         n;
    bit         pop_now;
    int         ld;
    logic [7:0] b[7];
    n = 0;
    pop_now = 1'b0;
    foreach (m_loads[i]) begin
      if (m_loads[i] >= c) n++;
      if (m_loads[i] == c) pop_now = 1'b1;
    end
    if (enable_tracking) begin
      if (n < DEPTH || pop_now) begin
        ld = c + 2;
        if (m_last_load + PKT_CYC + 2 > ld) ld = m_last_load + PKT_CYC + 2;
        m_loads.push_back(ld);
        m_last_load = ld;
        b[0] = 8'hA5;
        b[1] = m_frame;
        b[2] = {4'h0, point_x0[11:8]};
        b[3] = point_x0[7:0];
        b[4] = {5'h0, point_y0[10:8]};
        b[5] = point_y0[7:0];
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int i = 0; i < 7; i++) exp_bytes.push_back(b[i]);
      end else if (m_dropped != 8'hFF) begin
        m_dropped = m_dropped + 8'd1;
      end
    end
    m_frame = m_frame + 8'd1;
  endtask

  task automatic step(input logic vs);
    rx_vsync = vs;
    if (!rst && vs && !vs_prev) model_capture(cyc);
    vs_prev = vs;
    @(posedge rx_pclk);
    #1;
  endtask

  task automatic pulse(input int gap);
    step(1'b1);
    for (int i = 1; i < gap; i++) step(1'b0);
  endtask

  task automatic do_reset(input logic vs_level);
    rst = 1'b1;
    step(vs_level);
    step(vs_level);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic rand_point();
    point_x0 = 12'($urandom);
    point_y0 = 11'($urandom);
  endtask

  task automatic decode();
    int         i;
    logic [7:0] b;
    dec_bytes.delete();
    dec_first = -1;
    dec_err   = 0;
    i = 1;
    while (i < tx_log.size()) begin
      if (tx_log[i] == 1'b0 && tx_log[i-1] == 1'b1) begin
        if (i + 39 >= tx_log.size()) begin
          dec_err++;
          break;
        end
        if (dec_first < 0) dec_first = log_base + i;
        for (int k = 0; k < 8; k++) b[k] = tx_log[i + 4*(k+1) + 2];
        if (tx_log[i+2] !== 1'b0 || tx_log[i+38] !== 1'b1) dec_err++;
        dec_bytes.push_back(b);
        i += 40;
      end else begin
        i++;
      end
    end
  endtask

  task automatic finish_test(input string tag);
    int budget;
    int n;
    budget = 0;
    while ((busy !== 1'b0 || cyc <= m_last_load + PKT_CYC + 2) && budget < 20000) begin
      step(1'b0);
      budget++;
    end
    chk({tag, "_drain_timeout"}, 32'(budget >= 20000), 32'd0);
    decode();
    chk({tag, "_framing"}, 32'(dec_err), 32'd0);
    chk({tag, "_nbytes"}, 32'(dec_bytes.size()), 32'(exp_bytes.size()));
    n = (dec_bytes.size() < exp_bytes.size()) ? dec_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(dec_bytes[i]), 32'(exp_bytes[i]));
    chk({tag, "_dropped"}, 32'(dropped_count), 32'(m_dropped));
  endtask

  initial begin
    int c0, target, zeros;

    // 1: single packet, latency and reset state
    do_reset(1'b0);
    chk("t1_rst_tx", 32'(uart_tx), 32'd1);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_dropped", 32'(dropped_count), 32'd0);
    enable_tracking = 1'b1;
    point_x0 = 12'h123;
    point_y0 = 11'h045;
    c0 = cyc;
    step(1'b1);
    chk("t1_busy_early", 32'(busy), 32'd0);
    step(1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0);
    finish_test("t1");
    for (int i = 0; i < 7; i++) chk($sformatf("t1_const%0d", i), 32'(dec_bytes[i]), 32'(t1_exp[i]));
    chk("t1_start_cycle", 32'(dec_first), 32'(c0 + 3));

    // 2: vsync high across reset release, two disabled frames
    do_reset(1'b1);
    enable_tracking = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1);
    step(1'b0);
    pulse(20);
    pulse(20);
    enable_tracking = 1'b1;
    point_x0 = 12'h7FF;
    point_y0 = 11'h3FF;
    pulse(20);
    finish_test("t2");
    for (int i = 0; i < 7; i++) chk($sformatf("t2_const%0d", i), 32'(dec_bytes[i]), 32'(t2_exp[i]));

    // 3: burst of six captures overflows by one
    do_reset(1'b0);
    enable_tracking = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_point();
      pulse(10);
    end
    finish_test("t3");
    chk("t3_dropped_const", 32'(dropped_count), 32'd1);
    chk("t3_nbytes_const", 32'(dec_bytes.size()), 32'd35);
    for (int p = 0; p < 5; p++) chk($sformatf("t3_frame%0d", p), 32'(dec_bytes[7*p+1]), 32'(p));

    // 4: drop saturation and frame counter wrap
    do_reset(1'b0);
    enable_tracking = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_point();
      pulse(2);
    end
    chk("t4_saturated", 32'(dropped_count), 32'd255);
    enable_tracking = 1'b0;
    for (int i = 0; i < 212; i++) pulse(4);
    enable_tracking = 1'b1;
    rand_point();
    pulse(2);
    finish_test("t4");
    chk("t4_wrap_frame", 32'(dec_bytes[dec_bytes.size() - 6]), 32'd0);

    // 5: reset in the middle of a packet
    do_reset(1'b0);
    enable_tracking = 1'b1;
    rand_point();
    c0 = cyc;
    pulse(2);
    target = c0 + 2 + 1 + 30 * CPB;
    while (cyc < target) step(1'b0);
    chk("t5_mid_startbit", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    model_clear();
    chk("t5_tx_after_rst", 32'(uart_tx), 32'd1);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      if (uart_tx !== 1'b1) zeros++;
      step(1'b0);
    end
    chk("t5_quiet_line", 32'(zeros), 32'd0);
    rand_point();
    pulse(4);
    finish_test("t5");
    chk("t5_frame_zero", 32'(dec_bytes[1]), 32'd0);

    // 6: capture coincident with a pop while full
    do_reset(1'b0);
    enable_tracking = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_point();
      pulse(10);
    end
    chk("t6_dropped_pre", 32'(dropped_count), 32'd1);
    target = m_loads[1];
    while (cyc < target) step(1'b0);
    rand_point();
    pulse(2);
    chk("t6_dropped_same", 32'(dropped_count), 32'd1);
    finish_test("t6");
    chk("t6_nbytes_const", 32'(dec_bytes.size()), 32'd42);

    // 7: random spacing and enables
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      enable_tracking = ($urandom_range(0, 3) != 0);
      rand_point();
      pulse($urandom_range(2, 350));
    end
    finish_test("t7");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
